// File: rtl/hsv2rgb_pipe.sv
// Four-stage HSV-to-RGB converter with a valid/ready stream on both sides.
// While the output holds a pixel that has not been accepted, every stage freezes.
module hsv2rgb_pipe #(
    parameter int unsigned HUE_W = 9,
    parameter int unsigned CH_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HUE_W-1:0] h,
    input  logic [CH_W-1:0]  s,
    input  logic [CH_W-1:0]  v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  r,
    output logic [CH_W-1:0]  g,
    output logic [CH_W-1:0]  b
);

    localparam int unsigned PW = 2 * CH_W;
    localparam logic [CH_W-1:0] ChMax = {CH_W{1'b1}};

    logic w_stall;
    logic r_vld1, r_vld2, r_vld3, r_vld4;

    assign w_stall   = r_vld4 && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_vld4;

    // Stage 1: hue wrap and sector split
    logic [HUE_W-1:0] w_hw;
    logic [2:0]       w_sector;
    logic [5:0]       w_f;
    logic [2:0]       r1_sector;
    logic [5:0]       r1_f;
    logic [CH_W-1:0]  r1_s, r1_v;
    logic             r1_grey;

    assign w_hw = (h >= HUE_W'(360)) ? h - HUE_W'(360) : h;

    always_comb begin
        w_sector = 3'd0;
        w_f      = 6'(w_hw);
        if (w_hw >= HUE_W'(300)) begin
            w_sector = 3'd5;
            w_f      = 6'(w_hw - HUE_W'(300));
        end else if (w_hw >= HUE_W'(240)) begin
            w_sector = 3'd4;
            w_f      = 6'(w_hw - HUE_W'(240));
        end else if (w_hw >= HUE_W'(180)) begin
            w_sector = 3'd3;
            w_f      = 6'(w_hw - HUE_W'(180));
        end else if (w_hw >= HUE_W'(120)) begin
            w_sector = 3'd2;
            w_f      = 6'(w_hw - HUE_W'(120));
        end else if (w_hw >= HUE_W'(60)) begin
            w_sector = 3'd1;
            w_f      = 6'(w_hw - HUE_W'(60));
        end
    end

    // Stage 2: fractional ramp and first-level products
    logic [CH_W-1:0] w_ff, w_a, w_c, w_p;
    logic [2:0]      r2_sector;
    logic            r2_grey;
    logic [CH_W-1:0] r2_v, r2_a, r2_c, r2_p;

    // f*273/64 stretches 0..59 onto roughly 0..255
    assign w_ff = CH_W'((PW'(r1_f) * PW'(273)) >> 6);
    assign w_a  = CH_W'((PW'(r1_s) * PW'(w_ff)) >> CH_W);
    assign w_c  = CH_W'((PW'(r1_s) * PW'(ChMax - w_ff)) >> CH_W);
    assign w_p  = CH_W'((PW'(r1_v) * PW'(ChMax - r1_s)) >> CH_W);

    // Stage 3: falling and rising edges
    logic [CH_W-1:0] w_q, w_t;
    logic [2:0]      r3_sector;
    logic            r3_grey;
    logic [CH_W-1:0] r3_v, r3_p, r3_q, r3_t;

    assign w_q = CH_W'((PW'(r2_v) * PW'(ChMax - r2_a)) >> CH_W);
    assign w_t = CH_W'((PW'(r2_v) * PW'(ChMax - r2_c)) >> CH_W);

    // Stage 4: sector mux
    logic [CH_W-1:0] w_r, w_g, w_b;

    always_comb begin
        w_r = r3_v;
        w_g = r3_p;
        w_b = r3_p;
        unique case (r3_sector)
            3'd0: begin w_r = r3_v; w_g = r3_t; w_b = r3_p; end
            3'd1: begin w_r = r3_q; w_g = r3_v; w_b = r3_p; end
            3'd2: begin w_r = r3_p; w_g = r3_v; w_b = r3_t; end
            3'd3: begin w_r = r3_p; w_g = r3_q; w_b = r3_v; end
            3'd4: begin w_r = r3_t; w_g = r3_p; w_b = r3_v; end
            default: begin w_r = r3_v; w_g = r3_p; w_b = r3_q; end
        endcase
        // Grey pixels skip the truncated products so the output equals v exactly
        if (r3_grey) begin
            w_r = r3_v;
            w_g = r3_v;
            w_b = r3_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_sector <= w_sector;
            r1_f      <= w_f;
            r1_s      <= s;
            r1_v      <= v;
            r1_grey   <= (s == '0);
            r2_sector <= r1_sector;
            r2_grey   <= r1_grey;
            r2_v      <= r1_v;
            r2_a      <= w_a;
            r2_c      <= w_c;
            r2_p      <= w_p;
            r3_sector <= r2_sector;
            r3_grey   <= r2_grey;
            r3_v      <= r2_v;
            r3_p      <= r2_p;
            r3_q      <= w_q;
            r3_t      <= w_t;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
            r_vld3 <= 1'b0;
            r_vld4 <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else if (!w_stall) begin
            r_vld1 <= in_valid;
            r_vld2 <= r_vld1;
            r_vld3 <= r_vld2;
            r_vld4 <= r_vld3;
            r      <= w_r;
            g      <= w_g;
            b      <= w_b;
        end
    end

endmodule
